// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
package serial_pkg;

    localparam int unsigned SERIAL_DATA_BITS     = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with extra-MSB pointers; writes while full and reads while empty are ignored.
module serial_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/serial_tx_uart.sv
// Buffers processor serial bytes and shifts them out as 8N1 UART frames.
module serial_tx_uart
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SERIAL_DATA_BITS-1:0] serial_in,
    input  logic                        serial_wren_in,
    output logic                        serial_ready_out,
    output logic                        tx_out,
    output logic                        busy_out,
    output logic                        overflow_out
);

    localparam int unsigned       CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]        BIT_LAST = 3'(SERIAL_DATA_BITS - 1);

    tx_state_t                   state_q;
    logic [SERIAL_DATA_BITS-1:0] shift_q;
    logic [2:0]                  bit_idx_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        tx_q;
    logic                        ovf_q;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic [SERIAL_DATA_BITS-1:0] fifo_data;
    logic                        bit_done;
    logic                        pop;

    serial_fifo #(
        .WIDTH(SERIAL_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clock),
        .rst_ni (reset),
        .push_i (serial_wren_in),
        .data_i (serial_in),
        .pop_i  (pop),
        .data_o (fifo_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign bit_done = (cnt_q == CNT_LAST);
    // Pop from IDLE, or on the last stop-bit cycle so the next frame follows with no gap.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && bit_done));

    assign serial_ready_out = !fifo_full;
    assign tx_out           = tx_q;
    assign busy_out         = (state_q != IDLE) || !fifo_empty;
    assign overflow_out     = ovf_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            if (serial_wren_in && fifo_full) ovf_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q   <= fifo_data;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (bit_idx_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shift_q   <= fifo_data;
                            bit_idx_q <= '0;
                            tx_q      <= 1'b0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
